regfile_port_arbiter: RTL and testbench

Shares the register file's two synchronous read ports and single write port among `NUM_REQ` requesters, such as a fetch/decode unit and a debug/load unit, through a valid/ready handshake. Each accepted transaction reads two registers and optionally writes one in the same cycle. Read data returns one cycle later, tagged with the winning requester. Arbitration is round-robin, with an optional bounded lock that lets one requester issue back-to-back bursts.

---
 rtl/regfile_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares a register file's two synchronous read ports and its single write
// port among NUM_REQ requesters. Arbitration is round-robin. A requester can
// also hold a bounded lock to issue back-to-back transactions. Read data
// comes back one cycle after the accept, tagged by a one-hot rsp_valid.
module regfile_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs1,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs2,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata1,
    output logic [DATA_WIDTH-1:0]         rsp_rdata2,
    output logic [ADDR_WIDTH-1:0]         rf_reg_read1,
    output logic [ADDR_WIDTH-1:0]         rf_reg_read2,
    output logic [ADDR_WIDTH-1:0]         rf_reg_write,
    output logic [DATA_WIDTH-1:0]         rf_data_write,
    output logic                          rf_write_enable,
    input  logic [DATA_WIDTH-1:0]         rf_data_read1,
    input  logic [DATA_WIDTH-1:0]         rf_data_read2
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [3:0]           lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]   rr_grant_s;
    logic [PTR_W-1:0]     rr_idx_s;
    logic                 rr_found_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic [NUM_REQ-1:0]   accept_s;
    logic                 lock_more_s;

    // Next requester index with wrap-around (NUM_REQ need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (int'(p) >= NUM_REQ - 1) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    // Requester index k positions above ptr, modulo NUM_REQ.
    function automatic int rr_index(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    endfunction

    // One-hot vector with bit p set.
    function automatic logic [NUM_REQ-1:0] ptr_onehot(input logic [PTR_W-1:0] p);
        logic [NUM_REQ-1:0] r;
        r    = {NUM_REQ{1'b0}};
        r[p] = 1'b1;
        return r;
    endfunction

    // Round-robin search: first valid requester at or above rr_ptr.
    always_comb begin
        rr_grant_s = {NUM_REQ{1'b0}};
        rr_idx_s   = PTR_ZERO;
        rr_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found_s && req_valid[rr_index(rr_ptr_q, k)]) begin
                rr_grant_s[rr_index(rr_ptr_q, k)] = 1'b1;
                rr_idx_s   = PTR_W'(rr_index(rr_ptr_q, k));
                rr_found_s = 1'b1;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // A locked owner may continue only while its grant count stays below MAX_LOCK.
    assign lock_more_s = ({1'b0, lock_cnt_q} + 5'd1) < 5'(MAX_LOCK);

    // Arbitration FSM: next state, pointer/owner/lock-count updates and grant.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        ready_s    = {NUM_REQ{1'b0}};
        case (state_q)
            ST_ARB: begin
                ready_s = rr_grant_s;
                if (rr_found_s) begin
                    if (req_lock[rr_idx_s] && (MAX_LOCK > 1)) begin
                        state_d    = ST_LOCKED;
                        owner_d    = rr_idx_s;
                        lock_cnt_d = 4'd1;
                    end else begin
                        rr_ptr_d = ptr_inc(rr_idx_s);
                    end
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_LOCKED: begin
                ready_s = ptr_onehot(owner_q);
                if (req_valid[owner_q] && req_lock[owner_q] && lock_more_s) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end else begin
                    // Either the final locked grant or the owner withdrew.
                    state_d    = ST_ARB;
                    rr_ptr_d   = ptr_inc(owner_q);
                    lock_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = ST_ARB;
                lock_cnt_d = 4'd0;
            end
        endcase
        // No grant may be presented while reset is asserted.
        ready_s = ready_s & {NUM_REQ{rst_n}};
    end

    assign req_ready   = ready_s;
    assign accept_s    = req_valid & ready_s;
    assign rsp_valid_d = accept_s;

    // Register-file port mux: drive the accepted requester's fields, else zeros.
    always_comb begin
        rf_reg_read1    = {ADDR_WIDTH{1'b0}};
        rf_reg_read2    = {ADDR_WIDTH{1'b0}};
        rf_reg_write    = {ADDR_WIDTH{1'b0}};
        rf_data_write   = {DATA_WIDTH{1'b0}};
        rf_write_enable = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_s[i]) begin
                rf_reg_read1    = req_rs1[i*ADDR_WIDTH +: ADDR_WIDTH];
                rf_reg_read2    = req_rs2[i*ADDR_WIDTH +: ADDR_WIDTH];
                rf_reg_write    = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                rf_data_write   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                // r0 is hardwired zero, so writes to it are suppressed.
                rf_write_enable = req_we[i] &
                                  (req_rd[i*ADDR_WIDTH +: ADDR_WIDTH] != {ADDR_WIDTH{1'b0}});
            end else begin
                rf_write_enable = rf_write_enable;
            end
        end
    end

    // State, pointer, lock and response-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= PTR_ZERO;
            owner_q     <= PTR_ZERO;
            lock_cnt_q  <= 4'd0;
            rsp_valid_q <= {NUM_REQ{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata1 = rf_data_read1;
    assign rsp_rdata2 = rf_data_read2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: directed stimulus against a small
// register-file model, with response expectations queued on a scoreboard.
module tb_regfile_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_lock, req_we, rsp_valid;
    logic [N*AW-1:0] req_rs1, req_rs2, req_rd;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata1, rsp_rdata2, rf_data_write, rf_data_read1, rf_data_read2;
    logic [AW-1:0]   rf_reg_read1, rf_reg_read2, rf_reg_write;
    logic            rf_write_enable;

    logic            valid_a [N];
    logic            lock_a  [N];
    logic            we_a    [N];
    logic [AW-1:0]   rs1_a   [N];
    logic [AW-1:0]   rs2_a   [N];
    logic [AW-1:0]   rd_a    [N];
    logic [DW-1:0]   wdata_a [N];

    assign req_valid = {valid_a[1], valid_a[0]};
    assign req_lock  = {lock_a[1], lock_a[0]};
    assign req_we    = {we_a[1], we_a[0]};
    assign req_rs1   = {rs1_a[1], rs1_a[0]};
    assign req_rs2   = {rs2_a[1], rs2_a[0]};
    assign req_rd    = {rd_a[1], rd_a[0]};
    assign req_wdata = {wdata_a[1], wdata_a[0]};

    regfile_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
        .rf_reg_read1(rf_reg_read1), .rf_reg_read2(rf_reg_read2), .rf_reg_write(rf_reg_write),
        .rf_data_write(rf_data_write), .rf_write_enable(rf_write_enable),
        .rf_data_read1(rf_data_read1), .rf_data_read2(rf_data_read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 0) ? 32'h0000_0000 : (32'h1000_0000 + 32'(i));
    endfunction

    // Register file environment: registered reads sample before the write commits.
    logic          tb_load;
    logic [DW-1:0] regs [32];
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
        end else if (rf_write_enable) begin
            regs[rf_reg_write] <= rf_data_write;
        end
        rf_data_read1 <= regs[rf_reg_read1];
        rf_data_read2 <= regs[rf_reg_read2];
    end

    typedef struct {
        logic [N-1:0]  v;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } rsp_t;

    rsp_t          sb [$];
    logic [DW-1:0] ref_regs [32];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic lk,
                           input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [AW-1:0] rd, input logic we, input logic [DW-1:0] wd);
        valid_a[i] = v;  lock_a[i] = lk;
        rs1_a[i]   = r1; rs2_a[i]  = r2;
        rd_a[i]    = rd; we_a[i]   = we; wdata_a[i] = wd;
    endtask

    // One transaction cycle: check grant and port drive, retire the previous
    // response from the scoreboard, queue this cycle's expected response.
    task automatic do_cycle(input logic [N-1:0] exp_rdy, input string tag);
        int            g;
        logic [N-1:0]  acc;
        rsp_t          e;
        rsp_t          n;
        logic [AW-1:0] e_r1, e_r2, e_wa;
        logic [DW-1:0] e_wd;
        logic          e_we;
        #1;
        chk({tag, "_ready"}, DW'(req_ready), DW'(exp_rdy));
        acc  = exp_rdy & {valid_a[1], valid_a[0]};
        g    = acc[1] ? 1 : 0;
        e_r1 = 5'd0; e_r2 = 5'd0; e_wa = 5'd0; e_wd = 32'h0; e_we = 1'b0;
        if (acc != 2'b00) begin
            e_r1 = rs1_a[g]; e_r2 = rs2_a[g]; e_wa = rd_a[g]; e_wd = wdata_a[g];
            e_we = we_a[g] && (rd_a[g] != 5'd0);
        end
        chk({tag, "_rd1_addr"}, DW'(rf_reg_read1), DW'(e_r1));
        chk({tag, "_rd2_addr"}, DW'(rf_reg_read2), DW'(e_r2));
        chk({tag, "_wr_addr"},  DW'(rf_reg_write), DW'(e_wa));
        chk({tag, "_wr_data"},  rf_data_write, e_wd);
        chk({tag, "_wr_en"},    DW'(rf_write_enable), DW'(e_we));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, DW'(rsp_valid), DW'(e.v));
            if (e.v != 2'b00) begin
                chk({tag, "_rsp_rdata1"}, rsp_rdata1, e.d1);
                chk({tag, "_rsp_rdata2"}, rsp_rdata2, e.d2);
            end
        end
        n.v  = acc;
        n.d1 = ref_regs[e_r1];
        n.d2 = ref_regs[e_r2];
        sb.push_back(n);
        if (e_we) ref_regs[e_wa] = e_wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_t z;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        // Reset held with every requester valid and writing.
        rst_n   = 1'b0;
        tb_load = 1'b1;
        set_req(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 32'h1111_1111);
        set_req(1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd3, 1'b1, 32'h2222_2222);
        @(posedge clk); #1;
        chk("reset_ready", DW'(req_ready), 32'h0);
        chk("reset_rsp_valid", DW'(rsp_valid), 32'h0);
        chk("reset_wr_en", DW'(rf_write_enable), 32'h0);
        @(posedge clk); #1;
        tb_load = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
        rst_n = 1'b1;

        // Round-robin between two continuous requesters.
        do_cycle(2'b01, "rr0");
        do_cycle(2'b10, "rr1");
        do_cycle(2'b01, "rr2");
        do_cycle(2'b10, "rr3");

        // Same-transaction write/read returns old data; next-cycle read sees new.
        set_req(0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 32'hA5A5_0001);
        set_req(1, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "wr_rd0");
        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b10, "wr_rd1");

        // Write to r0 is suppressed.
        set_req(0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "wr_r0");
        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b10, "rd_r0");

        // Move priority to requester 1, then a full 4-grant lock burst.
        set_req(0, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 1'b0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "pre_lock");
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 32'hC0DE_0000 + 32'(k));
            do_cycle(2'b10, $sformatf("lock%0d", k));
        end
        do_cycle(2'b01, "lock_end");

        // Lock again, owner withdraws after two grants.
        do_cycle(2'b10, "lock2_0");
        do_cycle(2'b10, "lock2_1");
        set_req(1, 1'b0, 1'b0, 5'd7, 5'd2, 5'd7, 1'b0, 32'h0);
        do_cycle(2'b10, "drop");
        set_req(1, 1'b1, 1'b0, 5'd7, 5'd2, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "after_drop");

        // Reset pulse right after an accept drops the in-flight response.
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "pre_rst");
        set_req(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 32'h0BAD_0009);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", DW'(rsp_valid), 32'h0);
        chk("midrst_ready", DW'(req_ready), 32'h0);
        chk("midrst_wr_en", DW'(rf_write_enable), 32'h0);
        rst_n = 1'b1;
        sb.delete();
        z.v = 2'b00; z.d1 = 32'h0; z.d2 = 32'h0;
        sb.push_back(z);
        set_req(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b01, "post_rst");
        set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        do_cycle(2'b00, "idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
